issue_dispatch: RTL and testbench

//  Dual-issue dispatch stage, directly downstream of the issue buffer.
//  - Each cycle, examines the two oldest buffered instructions (slot A = older, slot B = younger).
//  - Decides in-order issue of 0/1/2 instructions: scoreboard RAW, intra-pair RAW/WAW, class conflicts.
//  - Returns o_usingNUM combinationally to the buffer for its tail advance.
//  - Registers issued instructions into the EX pipe registers.

---
 rtl/issue_dispatch_pkg.sv | 22 ++
 rtl/issue_dispatch_if.sv | 33 +++
 rtl/issue_dispatch_scoreboard.sv | 56 +++++
 rtl/issue_dispatch.sv | 106 ++++++++++
 tb/tb_issue_dispatch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/issue_dispatch_pkg.sv
// Shared types and defaults for the dual-issue dispatch stage.
// The instruction-class enum is common with the issue buffer and EX.
package issue_dispatch_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MDU  = 2'd2,
    CLS_BR   = 2'd3
  } instr_class_e;

  typedef logic [1:0] sb_cnt_t;

  localparam int unsigned LOAD_LAT_DEF = 2;
  localparam int unsigned MDU_LAT_DEF  = 3;
  localparam int unsigned REG_W        = 5;

  function automatic logic is_long_lat(input instr_class_e c);
    return (c == CLS_LOAD) || (c == CLS_MDU);
  endfunction

endpackage

// File: rtl/issue_dispatch_if.sv
// Issue buffer <-> dispatch handshake: the two oldest slots plus the
// combinational consumed-count returned to the buffer.
interface issue_dispatch_if #(
  parameter int PAYLOAD_W = 64
);
  import issue_dispatch_pkg::*;

  logic [1:0]           i_is_valid;
  logic [4:0]           i_a_rs1, i_a_rs2, i_a_rd;
  logic                 i_a_rs1_en, i_a_rs2_en, i_a_we;
  instr_class_e         i_a_class;
  logic [PAYLOAD_W-1:0] i_a_payload;
  logic [4:0]           i_b_rs1, i_b_rs2, i_b_rd;
  logic                 i_b_rs1_en, i_b_rs2_en, i_b_we;
  instr_class_e         i_b_class;
  logic [PAYLOAD_W-1:0] i_b_payload;
  logic [1:0]           o_usingNUM;

  modport master (
    output i_is_valid,
    output i_a_rs1, i_a_rs2, i_a_rd, i_a_rs1_en, i_a_rs2_en, i_a_we, i_a_class, i_a_payload,
    output i_b_rs1, i_b_rs2, i_b_rd, i_b_rs1_en, i_b_rs2_en, i_b_we, i_b_class, i_b_payload,
    input  o_usingNUM
  );

  modport slave (
    input  i_is_valid,
    input  i_a_rs1, i_a_rs2, i_a_rd, i_a_rs1_en, i_a_rs2_en, i_a_we, i_a_class, i_a_payload,
    input  i_b_rs1, i_b_rs2, i_b_rd, i_b_rs1_en, i_b_rs2_en, i_b_we, i_b_class, i_b_payload,
    output o_usingNUM
  );

endinterface

// File: rtl/issue_dispatch_scoreboard.sv
// Per-register busy counters for long-latency results (r1..r31) with a
// four-port hazard query: ports 0/1 for slot A sources, 2/3 for slot B.
module issue_scoreboard
  import issue_dispatch_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MDU_LAT  = MDU_LAT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_stall,
  input  logic [3:0][4:0]  i_q_addr,
  input  logic [3:0]       i_q_en,
  output logic [3:0]       o_hz,
  input  logic             i_set_a,
  input  logic [4:0]       i_set_a_rd,
  input  instr_class_e     i_set_a_class,
  input  logic             i_set_b,
  input  logic [4:0]       i_set_b_rd,
  input  instr_class_e     i_set_b_class
);

  localparam sb_cnt_t LOAD_CNT = sb_cnt_t'(LOAD_LAT);
  localparam sb_cnt_t MDU_CNT  = sb_cnt_t'(MDU_LAT);

  sb_cnt_t r_cnt [1:31];
  sb_cnt_t w_set_a_val, w_set_b_val;

  assign w_set_a_val = (i_set_a_class == CLS_LOAD) ? LOAD_CNT : MDU_CNT;
  assign w_set_b_val = (i_set_b_class == CLS_LOAD) ? LOAD_CNT : MDU_CNT;

  always_comb begin
    o_hz = '0;
    for (int p = 0; p < 4; p++) begin
      if (i_q_en[p] && (i_q_addr[p] != 5'd0))
        o_hz[p] = (r_cnt[i_q_addr[p]] != '0);
    end
  end

  // Slot B set has priority over slot A set; both beat the drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (i_set_b && (i_set_b_rd == 5'(r)))
          r_cnt[r] <= w_set_b_val;
        else if (i_set_a && (i_set_a_rd == 5'(r)))
          r_cnt[r] <= w_set_a_val;
        else if (!i_stall && (r_cnt[r] != '0))
          r_cnt[r] <= r_cnt[r] - sb_cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/issue_dispatch.sv
// Dual-issue in-order dispatch: decides 0/1/2 issue from the two oldest
// buffered instructions and registers the issued pair into EX.
module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int LOAD_LAT  = LOAD_LAT_DEF,
  parameter int MDU_LAT   = MDU_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  issue_dispatch_if.slave      bus,
  input  logic                 i_ex_stall,
  input  logic                 i_flush,
  output logic [1:0]           o_ex_valid,
  output logic [PAYLOAD_W-1:0] o_ex_a_payload,
  output logic [PAYLOAD_W-1:0] o_ex_b_payload,
  output logic [4:0]           o_ex_a_rd,
  output logic [4:0]           o_ex_b_rd,
  output logic                 o_ex_a_we,
  output logic                 o_ex_b_we
);

  logic [3:0] w_hz;
  logic       w_valid_a, w_valid_b;
  logic       w_raw, w_waw, w_cls;
  logic       w_issA, w_issB;

  logic [1:0]           r_ex_valid;
  logic [PAYLOAD_W-1:0] r_ex_a_payload, r_ex_b_payload;
  logic [4:0]           r_ex_a_rd, r_ex_b_rd;
  logic                 r_ex_a_we, r_ex_b_we;

  issue_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .MDU_LAT  (MDU_LAT)
  ) u_sb (
    .clk           (clk),
    .rstn          (rstn),
    .i_stall       (i_ex_stall),
    .i_q_addr      ({bus.i_b_rs2, bus.i_b_rs1, bus.i_a_rs2, bus.i_a_rs1}),
    .i_q_en        ({bus.i_b_rs2_en, bus.i_b_rs1_en, bus.i_a_rs2_en, bus.i_a_rs1_en}),
    .o_hz          (w_hz),
    .i_set_a       (w_issA && bus.i_a_we && is_long_lat(bus.i_a_class)),
    .i_set_a_rd    (bus.i_a_rd),
    .i_set_a_class (bus.i_a_class),
    .i_set_b       (w_issB && bus.i_b_we && is_long_lat(bus.i_b_class)),
    .i_set_b_rd    (bus.i_b_rd),
    .i_set_b_class (bus.i_b_class)
  );

  // 2'b01 is not a legal buffer state and is treated as empty.
  assign w_valid_a = bus.i_is_valid[1];
  assign w_valid_b = (bus.i_is_valid == 2'b11);

  assign w_raw = bus.i_a_we && (bus.i_a_rd != 5'd0) &&
                 ((bus.i_b_rs1_en && (bus.i_b_rs1 == bus.i_a_rd)) ||
                  (bus.i_b_rs2_en && (bus.i_b_rs2 == bus.i_a_rd)));
  assign w_waw = bus.i_a_we && bus.i_b_we && (bus.i_a_rd == bus.i_b_rd) &&
                 (bus.i_a_rd != 5'd0);
  assign w_cls = ((bus.i_a_class != CLS_ALU) && (bus.i_b_class != CLS_ALU)) ||
                 (bus.i_b_class == CLS_BR);

  assign w_issA = rstn && w_valid_a && !i_ex_stall && !i_flush && !w_hz[0] && !w_hz[1];
  assign w_issB = w_issA && w_valid_b && !w_hz[2] && !w_hz[3] && !w_raw && !w_waw && !w_cls;

  assign bus.o_usingNUM = {1'b0, w_issA} + {1'b0, w_issB};

  // EX pipe registers: flush outranks stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ex_valid     <= 2'b00;
      r_ex_a_payload <= '0;
      r_ex_b_payload <= '0;
      r_ex_a_rd      <= '0;
      r_ex_b_rd      <= '0;
      r_ex_a_we      <= 1'b0;
      r_ex_b_we      <= 1'b0;
    end else if (i_flush) begin
      r_ex_valid     <= 2'b00;
      r_ex_a_payload <= '0;
      r_ex_b_payload <= '0;
      r_ex_a_rd      <= '0;
      r_ex_b_rd      <= '0;
      r_ex_a_we      <= 1'b0;
      r_ex_b_we      <= 1'b0;
    end else if (!i_ex_stall) begin
      r_ex_valid     <= {w_issA, w_issB};
      r_ex_a_payload <= bus.i_a_payload;
      r_ex_b_payload <= bus.i_b_payload;
      r_ex_a_rd      <= bus.i_a_rd;
      r_ex_b_rd      <= bus.i_b_rd;
      r_ex_a_we      <= bus.i_a_we;
      r_ex_b_we      <= bus.i_b_we;
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_a_payload = r_ex_a_payload;
  assign o_ex_b_payload = r_ex_b_payload;
  assign o_ex_a_rd      = r_ex_a_rd;
  assign o_ex_b_rd      = r_ex_b_rd;
  assign o_ex_a_we      = r_ex_a_we;
  assign o_ex_b_we      = r_ex_b_we;

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch: expected EX records are queued as
// stimulus is issued and a monitor pops them as EX presents new data.
module tb_issue_dispatch;
  import issue_dispatch_pkg::*;

  localparam int PW = 64;

  typedef struct {
    logic [4:0]   rs1;
    logic         rs1_en;
    logic [4:0]   rs2;
    logic         rs2_en;
    logic [4:0]   rd;
    logic         we;
    instr_class_e cls;
    logic [PW-1:0] pl;
  } slot_t;

  typedef struct {
    logic [1:0] v;
    slot_t      a;
    slot_t      b;
  } exrec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_ex_stall = 1'b0;
  logic i_flush = 1'b0;
  logic [1:0]    o_ex_valid;
  logic [PW-1:0] o_ex_a_payload, o_ex_b_payload;
  logic [4:0]    o_ex_a_rd, o_ex_b_rd;
  logic          o_ex_a_we, o_ex_b_we;

  int n_checks = 0;
  int n_err = 0;
  exrec_t q[$];

  issue_dispatch_if #(.PAYLOAD_W(PW)) bus ();

  issue_dispatch #(.PAYLOAD_W(PW), .LOAD_LAT(2), .MDU_LAT(3)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus.slave),
    .i_ex_stall     (i_ex_stall),
    .i_flush        (i_flush),
    .o_ex_valid     (o_ex_valid),
    .o_ex_a_payload (o_ex_a_payload),
    .o_ex_b_payload (o_ex_b_payload),
    .o_ex_a_rd      (o_ex_a_rd),
    .o_ex_b_rd      (o_ex_b_rd),
    .o_ex_a_we      (o_ex_a_we),
    .o_ex_b_we      (o_ex_b_we)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic slot_t mk(input logic [4:0] rd, input logic we, input instr_class_e c,
                               input logic [4:0] rs1, input logic e1,
                               input logic [4:0] rs2, input logic e2, input logic [PW-1:0] pl);
    slot_t s;
    s.rs1 = rs1; s.rs1_en = e1; s.rs2 = rs2; s.rs2_en = e2;
    s.rd = rd; s.we = we; s.cls = c; s.pl = pl;
    return s;
  endfunction

  task automatic drive(input logic [1:0] v, input slot_t a, input slot_t b);
    bus.i_is_valid  = v;
    bus.i_a_rs1 = a.rs1; bus.i_a_rs1_en = a.rs1_en; bus.i_a_rs2 = a.rs2; bus.i_a_rs2_en = a.rs2_en;
    bus.i_a_rd  = a.rd;  bus.i_a_we = a.we; bus.i_a_class = a.cls; bus.i_a_payload = a.pl;
    bus.i_b_rs1 = b.rs1; bus.i_b_rs1_en = b.rs1_en; bus.i_b_rs2 = b.rs2; bus.i_b_rs2_en = b.rs2_en;
    bus.i_b_rd  = b.rd;  bus.i_b_we = b.we; bus.i_b_class = b.cls; bus.i_b_payload = b.pl;
  endtask

  // One cycle: drive just after the edge, check usingNUM, queue the expected EX record.
  task automatic step(input string nm, input logic [1:0] v, input slot_t a, input slot_t b,
                      input logic st, input logic fl, input logic [1:0] exp_use,
                      input logic [1:0] exp_ex);
    exrec_t r;
    @(posedge clk);
    #1;
    drive(v, a, b);
    i_ex_stall = st;
    i_flush = fl;
    #1;
    chk({nm, "_using"}, 64'(bus.o_usingNUM), 64'(exp_use));
    if (exp_ex != 2'b00) begin
      r.v = exp_ex; r.a = a; r.b = b;
      q.push_back(r);
    end
  endtask

  // Monitor: new EX data appears after any edge taken out of reset without stall or flush.
  initial begin
    logic upd;
    exrec_t r;
    forever begin
      @(posedge clk);
      upd = rstn && !i_ex_stall && !i_flush;
      @(negedge clk);
      if (upd && (o_ex_valid != 2'b00)) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL ex_unexpected actual=%0b required=none", o_ex_valid);
        end else begin
          r = q.pop_front();
          chk("ex_valid", 64'(o_ex_valid), 64'(r.v));
          if (r.v[1]) begin
            chk("ex_a_rd", 64'(o_ex_a_rd), 64'(r.a.rd));
            chk("ex_a_we", 64'(o_ex_a_we), 64'(r.a.we));
            chk("ex_a_pl", o_ex_a_payload, r.a.pl);
          end
          if (r.v[0]) begin
            chk("ex_b_rd", 64'(o_ex_b_rd), 64'(r.b.rd));
            chk("ex_b_we", 64'(o_ex_b_we), 64'(r.b.we));
            chk("ex_b_pl", o_ex_b_payload, r.b.pl);
          end
        end
      end
    end
  end

  initial begin
    slot_t nop, rd5, rd8;
    exrec_t r;
    nop = mk(5'd0, 1'b0, CLS_ALU, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    drive(2'b00, nop, nop);
    #12;
    chk("rst_ex_valid", 64'(o_ex_valid), 64'd0);
    chk("rst_ex_a_pl", o_ex_a_payload, 64'd0);
    chk("rst_using", 64'(bus.o_usingNUM), 64'd0);
    #5 rstn = 1'b1;

    // Independent ALU pair
    step("t1", 2'b11, mk(5'd1, 1'b1, CLS_ALU, 5'd2, 1'b1, 5'd0, 1'b0, 64'hA100),
                      mk(5'd3, 1'b1, CLS_ALU, 5'd4, 1'b1, 5'd0, 1'b0, 64'hB100), 0, 0, 2'd2, 2'b11);

    // Load r5 then dependent add: pair RAW, then two cycles of scoreboard hazard
    step("t2a", 2'b11, mk(5'd5, 1'b1, CLS_LOAD, 5'd6, 1'b1, 5'd0, 1'b0, 64'hA200),
                       mk(5'd7, 1'b1, CLS_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 64'hB200), 0, 0, 2'd1, 2'b10);
    rd5 = mk(5'd7, 1'b1, CLS_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 64'hA201);
    step("t2b", 2'b10, rd5, nop, 0, 0, 2'd0, 2'b00);
    step("t2c", 2'b10, rd5, nop, 0, 0, 2'd0, 2'b00);
    step("t2d", 2'b10, rd5, nop, 0, 0, 2'd1, 2'b10);

    // Class conflict, then pair RAW on r6
    step("t3a", 2'b11, mk(5'd8, 1'b1, CLS_MDU, 5'd9, 1'b1, 5'd10, 1'b1, 64'hA300),
                       mk(5'd11, 1'b1, CLS_LOAD, 5'd12, 1'b1, 5'd0, 1'b0, 64'hB300), 0, 0, 2'd1, 2'b10);
    step("t3b", 2'b11, mk(5'd6, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA310),
                       mk(5'd13, 1'b1, CLS_ALU, 5'd6, 1'b1, 5'd0, 1'b0, 64'hB310), 0, 0, 2'd1, 2'b10);

    // Stall holds EX and the r8 counter; flush under stall clears EX
    step("t4a", 2'b11, mk(5'd14, 1'b1, CLS_ALU, 5'd15, 1'b1, 5'd0, 1'b0, 64'hA400),
                       mk(5'd16, 1'b1, CLS_ALU, 5'd17, 1'b1, 5'd0, 1'b0, 64'hB400), 1, 0, 2'd0, 2'b00);
    step("t4b", 2'b11, mk(5'd14, 1'b1, CLS_ALU, 5'd15, 1'b1, 5'd0, 1'b0, 64'hA400),
                       mk(5'd16, 1'b1, CLS_ALU, 5'd17, 1'b1, 5'd0, 1'b0, 64'hB400), 1, 1, 2'd0, 2'b00);
    chk("stall_hold_valid", 64'(o_ex_valid), 64'b10);
    chk("stall_hold_rd", 64'(o_ex_a_rd), 64'd6);
    chk("stall_hold_pl", o_ex_a_payload, 64'hA310);
    rd8 = mk(5'd18, 1'b1, CLS_ALU, 5'd8, 1'b1, 5'd0, 1'b0, 64'hA410);
    step("t4c", 2'b10, rd8, nop, 0, 0, 2'd0, 2'b00);
    chk("flush_valid", 64'(o_ex_valid), 64'b00);
    chk("flush_rd", 64'(o_ex_a_rd), 64'd0);
    step("t4d", 2'b10, rd8, nop, 0, 0, 2'd0, 2'b00);
    step("t4e", 2'b10, rd8, nop, 0, 0, 2'd1, 2'b10);

    // B is branch/store; WAW; B-only scoreboard hazard
    step("t4f", 2'b11, mk(5'd19, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA420),
                       mk(5'd0, 1'b0, CLS_BR, 5'd2, 1'b1, 5'd3, 1'b1, 64'hB420), 0, 0, 2'd1, 2'b10);
    step("t4g", 2'b11, mk(5'd20, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA430),
                       mk(5'd20, 1'b1, CLS_ALU, 5'd2, 1'b1, 5'd0, 1'b0, 64'hB430), 0, 0, 2'd1, 2'b10);
    step("t4h", 2'b10, mk(5'd23, 1'b1, CLS_LOAD, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA440),
                       nop, 0, 0, 2'd1, 2'b10);
    step("t4i", 2'b11, mk(5'd24, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA450),
                       mk(5'd25, 1'b1, CLS_ALU, 5'd23, 1'b1, 5'd0, 1'b0, 64'hB450), 0, 0, 2'd1, 2'b10);

    // r0 is never a dependency; illegal valid pattern issues nothing
    step("t5a", 2'b11, mk(5'd0, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA500),
                       mk(5'd2, 1'b1, CLS_ALU, 5'd0, 1'b1, 5'd0, 1'b1, 64'hB500), 0, 0, 2'd2, 2'b11);
    step("t5b", 2'b01, mk(5'd26, 1'b1, CLS_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA510),
                       mk(5'd27, 1'b1, CLS_ALU, 5'd2, 1'b1, 5'd0, 1'b0, 64'hB510), 0, 0, 2'd0, 2'b00);

    // Reset with r5 busy and EX occupied
    step("t6a", 2'b10, mk(5'd5, 1'b1, CLS_LOAD, 5'd1, 1'b1, 5'd0, 1'b0, 64'hA600),
                       nop, 0, 0, 2'd1, 2'b10);
    rd5 = mk(5'd22, 1'b1, CLS_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 64'hA610);
    step("t6b", 2'b10, rd5, nop, 0, 0, 2'd0, 2'b00);
    #4 rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(o_ex_valid), 64'd0);
    chk("rst_mid_rd", 64'(o_ex_a_rd), 64'd0);
    chk("rst_mid_using", 64'(bus.o_usingNUM), 64'd0);
    #1 rstn = 1'b1;
    #1;
    chk("rst_rel_using", 64'(bus.o_usingNUM), 64'd1);
    r.v = 2'b10; r.a = rd5; r.b = nop;
    q.push_back(r);

    step("idle1", 2'b00, nop, nop, 0, 0, 2'd0, 2'b00);
    step("idle2", 2'b00, nop, nop, 0, 0, 2'd0, 2'b00);
    @(posedge clk);
    #6;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
